fft_sequencer: RTL
==================

# fft_sequencer

Control sequencer for an in-place radix-2 decimation-in-time FFT built around one `butterfly` instance and a dual-read/dual-write sample RAM. On `start` it walks all LOG2N stages. Each cycle it issues one butterfly's read addresses (a, b) and twiddle address, then issues the matching write-back addresses after the pipeline latency. Between stages it drains the pipeline so a stage never reads data the previous stage has not yet written. Input data is already in bit-reversed order in the RAM; loading and unloading are outside this block.

## Interface
- `LOG2N`, 4: log2 of FFT length N; legal range 2..12.
- `PIPE_LAT`, 2: cycles from read issue to butterfly result, i.e. RAM read latency 1 plus `cplx_mul` register 1; legal range ≥1.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a transform; sampled only in IDLE.
- `busy` out 1: high from the cycle after accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the final write has been issued.
- `rd_en` out 1: read strobe for both RAM read ports.
- `rd_addr_a`, `rd_addr_b` out LOG2N: butterfly inputs a (upper) and b (lower).
- `tw_addr` out LOG2N-1: twiddle ROM index k for W_N^k; the ROM has 1-cycle latency, aligned with RAM data.
- `wr_en` out 1: write strobe for both RAM write ports.
- `wr_addr_a`, `wr_addr_b` out LOG2N: destinations for y0 and y1.
- `stage` out clog2(LOG2N): current stage, for debug and scaling control.

## Operation
- FSM states: IDLE, RUN, DRAIN, FINISH.
  - IDLE→RUN on `start`.
  - RUN→DRAIN after pair k=N/2-1 is issued.
  - DRAIN→RUN (stage+1) after PIPE_LAT cycles if stage<LOG2N-1.
  - DRAIN→FINISH otherwise.
  - FINISH→IDLE unconditionally; `done`=1 in FINISH.
- Counters: stage s in 0..LOG2N-1; pair k in 0..N/2-1; drain counter in 0..PIPE_LAT-1. All are cleared on entering RUN from IDLE. k is also cleared on each new stage.
- Address math for pair k in stage s, with span=1<<s, grp=k>>s, pos=k&(span-1):
  - addr_a = (grp<<(s+1)) | pos
  - addr_b = addr_a + span
  - tw_addr = pos<<(LOG2N-1-s)
  - All unsigned. No overflow is possible: addr_b ≤ N-1.
- In RUN, `rd_en`=1 every cycle; k increments after each issue.
- Write side is a PIPE_LAT-deep shift register of {valid, addr_a, addr_b}. `wr_en`/`wr_addr_*` equal the `rd_en`/`rd_addr_*` values from exactly PIPE_LAT cycles earlier.
- Within a stage each address is read once and written once, so concurrent reads and writes never collide.
- `start` while busy: ignored, no restart.
- `rst` at any point: FSM→IDLE, counters cleared, and all write pipeline valids cleared. In-flight writes are dropped and never issued.

## Timing
- Reset values: `busy`, `done`, `rd_en`, `wr_en` are 0. All addresses and `stage` are 0.
- All outputs are registered.
- Let cycle 0 be the `start` edge in IDLE.
  - Stage s reads occupy cycles 1+s·(N/2+PIPE_LAT) through s·(N/2+PIPE_LAT)+N/2.
  - Each stage's writes trail its reads by PIPE_LAT cycles.
- Last write is at cycle LOG2N·(N/2+PIPE_LAT). `done` pulses the next cycle, and `busy` falls in that same cycle.
- For N=16 and PIPE_LAT=2: 32 reads, last write at cycle 40, `done` at cycle 41.
- A new `start` is accepted in the cycle after `done`.

## Structure
- Shared header `fft_defs.vh`:
  - LOG2N and PIPE_LAT defaults.
  - FSM state encodings.
  - `N`, `HALF_N`, and width localparams, so the RAM, twiddle ROM and sequencer agree.
- One combinational sub-module `fft_addr_gen`: (s, k) → (addr_a, addr_b, tw_addr).
- `fft_sequencer` holds the FSM, counters and the write-delay pipe.

## Test plan
- N=16, PIPE_LAT=2, reset then `start` at cycle 0:
  - `rd_en` high for exactly 32 cycles across 4 bursts of 8.
  - `done` high only at cycle 41.
  - `busy` high for cycles 1–40.
- Address spot checks:
  - Stage 0, k=0 → a=0, b=1, tw=0.
  - Stage 1, k=1 → a=1, b=3, tw=4.
  - Stage 2, k=4 → a=8, b=12, tw=0.
  - Stage 3, k=5 → a=5, b=13, tw=5.
- Write alignment: every `wr_en` pulse matches the `rd_addr` pair from 2 cycles earlier. No stage's first read precedes the previous stage's last write.
- `start` pulsed at cycles 5 and 20 during a run → ignored. Second `start` at cycle 42 → a clean second run ends with `done` at cycle 83.
- `rst` asserted at cycle 15 (mid stage 1):
  - Next cycle: `rd_en`=0, `wr_en`=0, `busy`=0, and no writes follow.
  - A subsequent `start` gives full nominal timing.
- End-to-end with a `butterfly`/RAM/ROM model, N=16, impulse at index 0 in bit-reversed order → all 16 outputs equal the impulse amplitude, imaginary parts 0.

Source files
------------

// File: rtl/fft_sequencer_pkg.sv
// Shared definitions for the FFT sequencer, its address generator, the sample RAM and the twiddle ROM.
package fft_sequencer_pkg;

  localparam int LOG2N_DEF    = 4;
  localparam int PIPE_LAT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  function automatic int n_of(int log2n);
    return 1 << log2n;
  endfunction

  function automatic int half_n_of(int log2n);
    return 1 << (log2n - 1);
  endfunction

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int stage_w(int log2n);
    return cnt_w(log2n);
  endfunction

endpackage

// File: rtl/fft_sequencer_addr_gen.sv
// Combinational radix-2 DIT address generator: (stage, pair) -> butterfly read/write and twiddle addresses.
module fft_addr_gen
  import fft_sequencer_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic [stage_w(LOG2N)-1:0] s,
  input  logic [LOG2N-2:0]          k,
  output logic [LOG2N-1:0]          addr_a,
  output logic [LOG2N-1:0]          addr_b,
  output logic [LOG2N-2:0]          tw_addr
);

  localparam int AW = LOG2N;
  localparam int KW = LOG2N - 1;
  localparam int SW = stage_w(LOG2N);

  logic [AW-1:0] k_w;
  logic [AW-1:0] span;
  logic [AW-1:0] pos;
  logic [AW-1:0] grp;
  logic [AW-1:0] a_w;
  logic [SW:0]   s_p1;
  logic [SW-1:0] tw_sh;

  always_comb begin
    k_w   = {1'b0, k};
    span  = AW'(1) << s;
    pos   = k_w & (span - AW'(1));
    grp   = k_w >> s;
    s_p1  = {1'b0, s} + (SW + 1)'(1);
    tw_sh = SW'(LOG2N - 1) - s;
    a_w   = (grp << s_p1) | pos;
  end

  assign addr_a  = a_w;
  assign addr_b  = a_w + span;
  // pos < span <= N/2, so the shifted twiddle index always fits in LOG2N-1 bits.
  assign tw_addr = pos[KW-1:0] << tw_sh;

endmodule

// File: rtl/fft_sequencer.sv
// In-place radix-2 DIT FFT control sequencer: issues butterfly reads per stage, drains the
// pipeline between stages, and replays each read's addresses as the write-back PIPE_LAT cycles later.
module fft_sequencer
  import fft_sequencer_pkg::*;
#(
  parameter int LOG2N    = LOG2N_DEF,
  parameter int PIPE_LAT = PIPE_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [LOG2N-1:0]          rd_addr_a,
  output logic [LOG2N-1:0]          rd_addr_b,
  output logic [LOG2N-2:0]          tw_addr,
  output logic                      wr_en,
  output logic [LOG2N-1:0]          wr_addr_a,
  output logic [LOG2N-1:0]          wr_addr_b,
  output logic [stage_w(LOG2N)-1:0] stage
);

  localparam int SW = stage_w(LOG2N);
  localparam int KW = LOG2N - 1;
  localparam int DW = cnt_w(PIPE_LAT);

  localparam logic [KW-1:0] K_LAST = KW'(half_n_of(LOG2N) - 1);
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);
  localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT - 1);

  typedef struct packed {
    logic             valid;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wr_slot_t;

  seq_state_e state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [KW-1:0] k_q, k_d;
  logic [DW-1:0] d_q, d_d;

  logic [LOG2N-1:0] gen_a;
  logic [LOG2N-1:0] gen_b;
  logic [KW-1:0]    gen_tw;

  wr_slot_t pipe [PIPE_LAT];

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s      (s_q),
    .k      (k_q),
    .addr_a (gen_a),
    .addr_b (gen_b),
    .tw_addr(gen_tw)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    d_d     = d_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          k_d     = '0;
          d_d     = '0;
        end
      end
      ST_RUN: begin
        k_d = k_q + KW'(1);
        if (k_q == K_LAST) begin
          state_d = ST_DRAIN;
          d_d     = '0;
        end
      end
      ST_DRAIN: begin
        d_d = d_q + DW'(1);
        if (d_q == D_LAST) begin
          d_d = '0;
          if (s_q == S_LAST) begin
            state_d = ST_FINISH;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + SW'(1);
            k_d     = '0;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      d_q     <= d_d;
    end
  end

  // Output register stage: every port is driven straight from a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      stage     <= '0;
      // NOTE: the delay pipe is a handful of flops, not a RAM; clearing it is what drops in-flight writes.
      for (int i = 0; i < PIPE_LAT; i++) pipe[i] <= '0;
    end else begin
      busy      <= (state_q == ST_RUN) || (state_q == ST_DRAIN);
      done      <= (state_q == ST_FINISH);
      rd_en     <= (state_q == ST_RUN);
      rd_addr_a <= gen_a;
      rd_addr_b <= gen_b;
      tw_addr   <= gen_tw;
      stage     <= s_q;
      pipe[0]   <= wr_slot_t'{valid: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign wr_en     = pipe[PIPE_LAT-1].valid;
  assign wr_addr_a = pipe[PIPE_LAT-1].a;
  assign wr_addr_b = pipe[PIPE_LAT-1].b;

endmodule
